// File: rtl/regbank_write_if.sv
// Write/clear port bundle of the register bank.
// The master drives writes and clears; the slave is the bank.
interface regbank_write_if #(
  parameter int NREGS = 32,
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic                         we3;
  logic [4:0]                   wa3;
  logic [WIDTH-1:0]             wd3;
  logic                         wr_ready;
  logic                         clr_req;
  logic                         busy;
  logic [NREGS-1:0][WIDTH-1:0]  registrador;
  logic [CNT_W-1:0]             wr_count;

  modport master (
    output we3, wa3, wd3, clr_req,
    input  wr_ready, busy, registrador, wr_count
  );

  modport slave (
    input  we3, wa3, wd3, clr_req,
    output wr_ready, busy, registrador, wr_count
  );
endinterface

// File: rtl/regbank_write.sv
// 32x32 register bank with writeback port and sequenced bulk clear.
// Option REGBANK_X0_ZERO_EN hardwires register 0 to zero.
module regbank_write #(
  parameter int NREGS = 32,
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input logic            clk,
  input logic            rst_n,
  regbank_write_if.slave bus
);
  typedef enum logic {
    IDLE,
    SWEEP
  } state_t;

  state_t                       state;
  logic [4:0]                   idx;
  logic [NREGS-1:0][WIDTH-1:0]  regs;
  logic [CNT_W-1:0]             cnt;

  assign bus.busy        = (state == SWEEP);
  assign bus.wr_ready    = (state == IDLE);
  assign bus.registrador = regs;
  assign bus.wr_count    = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      regs  <= '0;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.we3) begin
`ifdef REGBANK_X0_ZERO_EN
            if (bus.wa3 != 5'd0)
              regs[bus.wa3] <= bus.wd3;
`else
            regs[bus.wa3] <= bus.wd3;
`endif
            if (cnt != '1)
              cnt <= cnt + 1'b1;
          end
          // a same-edge write lands first; the sweep clears it later
          if (bus.clr_req) begin
            state <= SWEEP;
            idx   <= '0;
          end
        end
        SWEEP: begin
          regs[idx] <= '0;
          idx       <= idx + 1'b1;
          if (idx == 5'd31)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
